// File: rtl/id_r_issue_pkg.sv
// id_r_issue_pkg: shared opcode/funct values, instruction field positions and FSM states for the R-type issue path
package id_r_issue_pkg;
    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] FUNCT_JR    = 6'h08;
    localparam logic [5:0] FUNCT_JALR  = 6'h09;
    localparam int OP_LSB = 26;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    localparam int SH_LSB = 6;
    localparam int FN_LSB = 0;
    localparam logic [31:0] ZERO_WORD     = 32'd0;
    localparam logic [4:0]  ZERO_REG_ADDR = 5'd0;
    typedef enum logic {RUN = 1'b0, DSLOT = 1'b1} state_t;
endpackage

// File: rtl/id_r_issue_reg_scoreboard.sv
// reg_scoreboard: per-register write-back latency counters with a two-port hazard lookup
module reg_scoreboard #(
    parameter int REG_AW = 5,
    parameter int WB_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [REG_AW-1:0] load_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    input  logic              rd_en_1,
    input  logic [REG_AW-1:0] rd_addr_1,
    input  logic              rd_en_2,
    input  logic [REG_AW-1:0] rd_addr_2,
    output logic              hazard
);
    localparam int NREG = 2 ** REG_AW;
    logic [2:0] cnt [NREG];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= 3'd0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (load_en && load_addr == REG_AW'(i)) cnt[i] <= 3'(WB_LAT);
                else if (clr_en && clr_addr == REG_AW'(i)) cnt[i] <= 3'd0;
                else if (cnt[i] != 3'd0) cnt[i] <= cnt[i] - 3'd1;
            end
        end
    end
    assign hazard = (rd_en_1 && rd_addr_1 != '0 && cnt[rd_addr_1] != 3'd0) ||
                    (rd_en_2 && rd_addr_2 != '0 && cnt[rd_addr_2] != 3'd0);
endmodule

// File: rtl/id_r_issue.sv
// id_r_issue: registered R-type decode/issue with RAW scoreboard stalls and JR/JALR delay-slot tracking
module id_r_issue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5,
    parameter int WB_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       inst,
    input  logic              flush,
    output logic              reg_read_en_1,
    output logic              reg_read_en_2,
    output logic [REG_AW-1:0] reg_addr_1,
    output logic [REG_AW-1:0] reg_addr_2,
    input  logic [DATA_W-1:0] reg_val_mux_data_1,
    input  logic [DATA_W-1:0] reg_val_mux_data_2,
    output logic              inst_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] operand_1,
    output logic [DATA_W-1:0] operand_2,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic              write_reg_en,
    output logic [REG_AW-1:0] write_reg_addr,
    output logic              branch_flag,
    output logic [ADDR_W-1:0] branch_addr,
    output logic              dslot_err
);
    import id_r_issue_pkg::*;
    state_t            state, state_d;
    logic [5:0]        op, fn;
    logic [REG_AW-1:0] rd;
    logic              is_jr, is_jalr, is_jmp, nop, hazard, acc, acc_r, wen_d;
    logic [DATA_W-1:0] op1_d, op2_d;
    assign op         = inst[OP_LSB +: 6];
    assign fn         = inst[FN_LSB +: 6];
    assign rd         = REG_AW'(inst[RD_LSB +: 5]);
    assign reg_addr_1 = REG_AW'(inst[RS_LSB +: 5]);
    assign reg_addr_2 = REG_AW'(inst[RT_LSB +: 5]);
    assign inst_r     = op == OP_SPECIAL || op == OP_SPECIAL2;
    assign is_jr      = op == OP_SPECIAL && fn == FUNCT_JR;
    assign is_jalr    = op == OP_SPECIAL && fn == FUNCT_JALR;
    assign is_jmp     = is_jr || is_jalr;
    assign nop        = is_jmp && state == DSLOT;
    assign reg_read_en_1 = inst_r;
    assign reg_read_en_2 = inst_r && !is_jmp;
    // Non-R instructions are always taken (another decoder owns them), except during flush
    assign in_ready = !flush && (!inst_r || (!hazard && (!out_valid || out_ready)));
    assign acc      = in_valid && in_ready;
    assign acc_r    = acc && inst_r;
    assign wen_d    = !is_jr && !nop && rd != '0;
    assign op1_d    = (nop || is_jr) ? '0 : is_jalr ? DATA_W'(pc + ADDR_W'(8)) : reg_val_mux_data_1;
    assign op2_d    = is_jmp ? '0 : reg_val_mux_data_2;
    reg_scoreboard #(.REG_AW(REG_AW), .WB_LAT(WB_LAT)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .load_en   (acc_r && wen_d),
        .load_addr (rd),
        .clr_en    (flush && out_valid && write_reg_en),
        .clr_addr  (write_reg_addr),
        .rd_en_1   (reg_read_en_1),
        .rd_addr_1 (reg_addr_1),
        .rd_en_2   (reg_read_en_2),
        .rd_addr_2 (reg_addr_2),
        .hazard    (hazard)
    );
    always_comb begin
        state_d = state;
        if (flush) state_d = RUN;
        else if (acc) state_d = (is_jmp && state == RUN) ? DSLOT : RUN;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else state <= state_d;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            operand_1      <= '0;
            operand_2      <= '0;
            shamt          <= 5'd0;
            funct          <= 6'd0;
            write_reg_en   <= 1'b0;
            write_reg_addr <= '0;
            branch_flag    <= 1'b0;
            branch_addr    <= '0;
            dslot_err      <= 1'b0;
        end else begin
            branch_flag <= acc_r && is_jmp && !nop;
            if (acc_r && is_jmp && !nop) branch_addr <= ADDR_W'(reg_val_mux_data_1);
            if (acc_r && nop) dslot_err <= 1'b1;
            if (flush) out_valid <= 1'b0;
            else if (acc_r) begin
                out_valid      <= 1'b1;
                operand_1      <= op1_d;
                operand_2      <= op2_d;
                shamt          <= inst[SH_LSB +: 5];
                funct          <= fn;
                write_reg_en   <= wen_d;
                write_reg_addr <= rd;
            end else if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_r_issue.sv
// tb_id_r_issue: directed checks of reset, RAW stalls, JALR/JR delay slots, backpressure, flush and async reset
module tb_id_r_issue;
    logic        clk = 1'b0, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] pc, inst, d1, d2, operand_1, operand_2, branch_addr;
    logic        reg_read_en_1, reg_read_en_2, inst_r, write_reg_en, branch_flag, dslot_err;
    logic [4:0]  reg_addr_1, reg_addr_2, shamt, write_reg_addr;
    logic [5:0]  funct;
    int total = 0, bad = 0;
    id_r_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .inst(inst),
        .flush(flush), .reg_read_en_1(reg_read_en_1), .reg_read_en_2(reg_read_en_2),
        .reg_addr_1(reg_addr_1), .reg_addr_2(reg_addr_2), .reg_val_mux_data_1(d1),
        .reg_val_mux_data_2(d2), .inst_r(inst_r), .out_valid(out_valid), .out_ready(out_ready),
        .operand_1(operand_1), .operand_2(operand_2), .shamt(shamt), .funct(funct),
        .write_reg_en(write_reg_en), .write_reg_addr(write_reg_addr), .branch_flag(branch_flag),
        .branch_addr(branch_addr), .dslot_err(dslot_err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] rt(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                       input logic [4:0] sh, input logic [5:0] f);
        return {6'd0, s, t, d, sh, f};
    endfunction
    task automatic put(input logic v, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        in_valid = v; inst = i; d1 = a; d2 = b;
        #1;
    endtask
    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1; pc = 32'h0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'($urandom); pc = $urandom; d1 = $urandom; d2 = $urandom;
            inst = {6'h23, 26'($urandom)};
            tick();
        end
        chk("rst_out_valid", out_valid, 0);
        chk("rst_operands", {operand_1, operand_2}, 0);
        chk("rst_fields", {shamt, funct, write_reg_en, write_reg_addr}, 0);
        chk("rst_branch", {branch_flag, branch_addr, dslot_err}, 0);
        chk("rst_nonr_ready", {in_ready, inst_r, reg_read_en_1, reg_read_en_2}, 4'b1000);
        rst = 1'b1; pc = 32'h0;
        put(1, rt(1, 2, 3, 0, 6'h21), 5, 7);
        chk("addu_comb", {in_ready, inst_r, reg_read_en_1, reg_read_en_2, reg_addr_1, reg_addr_2}, {4'b1111, 5'd1, 5'd2});
        tick();
        chk("addu_out", {out_valid, operand_1, operand_2}, {1'b1, 32'd5, 32'd7});
        chk("addu_wb", {write_reg_en, write_reg_addr, funct, branch_flag}, {1'b1, 5'd3, 6'h21, 1'b0});
        put(1, rt(1, 2, 4, 0, 6'h21), 1, 2);
        tick();
        chk("prod_addr", write_reg_addr, 4);
        put(1, rt(4, 1, 5, 0, 6'h23), 9, 1);
        chk("raw_stall1", in_ready, 0);
        tick();
        chk("raw_stall2", in_ready, 0);
        chk("raw_drained", out_valid, 0);
        tick();
        chk("raw_release", in_ready, 1);
        tick();
        chk("raw_issue", {out_valid, operand_1, operand_2, write_reg_addr}, {1'b1, 32'd9, 32'd1, 5'd5});
        put(1, rt(0, 2, 6, 7, 6'h00), 0, 3);
        chk("indep_ready", in_ready, 1);
        tick();
        chk("indep_issue", {write_reg_addr, shamt, funct, operand_2}, {5'd6, 5'd7, 6'h00, 32'd3});
        put(1, rt(1, 2, 0, 0, 6'h21), 1, 1);
        tick();
        chk("rd0_nowrite", {out_valid, write_reg_en}, 2'b10);
        put(1, rt(0, 0, 9, 0, 6'h21), 0, 0);
        chk("rd0_nostall", in_ready, 1);
        tick();
        pc = 32'h100;
        put(1, rt(8, 0, 31, 0, 6'h09), 32'h2000, 0);
        tick();
        chk("jalr_branch", {branch_flag, branch_addr}, {1'b1, 32'h2000});
        chk("jalr_link", {operand_1, write_reg_en, write_reg_addr}, {32'h108, 1'b1, 5'd31});
        put(0, 32'h8c00_0000, 0, 0);
        tick();
        chk("jalr_pulse_end", branch_flag, 0);
        put(1, rt(10, 0, 0, 0, 6'h08), 32'h400, 0);
        tick();
        chk("dslot_nop", {out_valid, write_reg_en, branch_flag, dslot_err}, 4'b1001);
        put(1, rt(10, 0, 0, 0, 6'h08), 32'h400, 0);
        tick();
        chk("jr_run", {branch_flag, branch_addr, write_reg_en}, {1'b1, 32'h400, 1'b0});
        put(1, rt(11, 0, 0, 0, 6'h08), 32'h500, 0);
        tick();
        chk("jr_jr_nop", {branch_flag, write_reg_en, dslot_err}, 3'b001);
        put(1, rt(12, 0, 0, 0, 6'h08), 32'h800, 0);
        tick();
        chk("back_to_run", {branch_flag, branch_addr}, {1'b1, 32'h800});
        put(1, 32'h8c00_0000, 0, 0);
        chk("dslot_nonr_ready", in_ready, 1);
        tick();
        chk("nonr_no_issue", out_valid, 0);
        out_ready = 1'b0;
        put(1, rt(1, 2, 13, 0, 6'h21), 32'h11, 32'h22);
        tick();
        put(1, rt(1, 2, 14, 0, 6'h21), 32'h33, 32'h44);
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready_low", in_ready, 0);
            tick();
            chk("bp_hold", {out_valid, operand_1, operand_2, write_reg_addr}, {1'b1, 32'h11, 32'h22, 5'd13});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_drain_ready", in_ready, 1);
        tick();
        chk("bp_reload", {out_valid, operand_1, write_reg_addr}, {1'b1, 32'h33, 5'd14});
        put(1, rt(1, 2, 15, 0, 6'h21), 1, 2);
        tick();
        flush = 1'b1;
        put(1, rt(15, 1, 16, 0, 6'h23), 32'h70, 32'h7);
        chk("flush_no_acc", in_ready, 0);
        tick();
        chk("flush_discard", out_valid, 0);
        flush = 1'b0;
        #1;
        chk("flush_cnt_clr", in_ready, 1);
        tick();
        chk("flush_dep_issue", {out_valid, operand_1, write_reg_addr}, {1'b1, 32'h70, 5'd16});
        put(1, rt(10, 0, 0, 0, 6'h08), 32'h40, 0);
        tick();
        flush = 1'b1;
        put(0, 32'h8c00_0000, 0, 0);
        tick();
        flush = 1'b0;
        put(1, rt(11, 0, 0, 0, 6'h08), 32'h80, 0);
        tick();
        chk("flush_run", {branch_flag, branch_addr}, {1'b1, 32'h80});
        put(1, rt(1, 2, 17, 0, 6'h21), 3, 4);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_clear", {out_valid, dslot_err, branch_flag, write_reg_addr}, 0);
        rst = 1'b1;
        put(1, rt(17, 1, 18, 0, 6'h23), 32'h9, 32'h2);
        chk("arst_cnt_clr", in_ready, 1);
        tick();
        chk("arst_first_acc", {out_valid, operand_1, write_reg_addr}, {1'b1, 32'h9, 5'd18});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_r_issue.md
# id_r_issue

Registered, parametrised successor of the R-type decode path in the ID stage. It accepts IF-stage instructions over a valid/ready handshake and decodes SPECIAL/SPECIAL2 operations. It tracks in-flight destination registers in a per-register latency scoreboard and stalls on read-after-write hazards. It resolves JR/JALR with an explicit delay-slot state, then issues operands and write-back information to EX through a one-entry output register.

## Interface
Parameters:
- DATA_W, 32, operand/register data width
- ADDR_W, 32, PC/branch address width
- REG_AW, 5, register address width; register file has 2**REG_AW entries, register 0 hardwired zero
- WB_LAT, 2, cycles after acceptance before a produced register may be read (1..7)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  IF presents pc/inst
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- pc  in  ADDR_W  instruction address
- inst  in  32  instruction word
- flush  in  1  kill output register and delay-slot state
- reg_read_en_1 / reg_read_en_2  out  1  source read enables (combinational)
- reg_addr_1 / reg_addr_2  out  REG_AW  rs / rt (combinational)
- reg_val_mux_data_1 / _2  in  DATA_W  source values from RegReadProxy, same cycle
- inst_r  out  1  combinational: inst is SPECIAL/SPECIAL2
- out_valid  out  1  output register holds an instruction for EX
- out_ready  in  1  EX consumes when out_valid && out_ready
- operand_1 / operand_2  out  DATA_W  registered operands
- shamt  out  5  registered shift amount
- funct  out  6  registered funct field
- write_reg_en  out  1  registered write enable
- write_reg_addr  out  REG_AW  registered destination
- branch_flag  out  1  one-cycle pulse on JR/JALR acceptance
- branch_addr  out  ADDR_W  target, valid with branch_flag
- dslot_err  out  1  sticky: jump found in a delay slot

## Operation
- Non-R-type instruction: in_ready = 1, read enables low, nothing issued. Another decoder owns it.
- R-type accept condition: in_valid && !hazard && (!out_valid || out_ready).
- Hazard: read-enabled source register r != 0 with cnt[r] != 0.
- Scoreboard holds one counter cnt[r] per register, 3 bits wide.
  - On acceptance with write_reg_en && rd != 0, load cnt[rd] = WB_LAT.
  - Otherwise each nonzero counter decrements every cycle.
  - When load and decrement hit the same register in the same cycle, load wins.
- Decode:
  - JR: no write, branch_addr = rs value.
  - JALR: operand_1 = pc+8 (mod 2**ADDR_W), write rd, branch_addr = rs value.
  - All other R-type: operand_1 = rs value, operand_2 = rt value, write rd.
  - rd = 0 forces write_reg_en = 0.
- FSM, states RUN and DSLOT:
  - RUN -> DSLOT when a JR/JALR is accepted.
  - DSLOT -> RUN when the next instruction of any type is accepted.
  - A JR/JALR accepted in DSLOT issues as a NOP (write disabled, no branch pulse) and sets dslot_err.
- flush:
  - Clears out_valid.
  - Clears cnt[rd] of the flushed entry if it was loaded by that entry.
  - Forces RUN. No acceptance occurs in the flush cycle.
- Reset values: out_valid 0, all registered outputs 0, every cnt 0, FSM RUN, branch_flag 0, dslot_err 0.

## Timing
- Latency: accepted at edge t -> out_valid and fields visible after edge t (1 cycle).
- Output register holds stable while out_valid && !out_ready. A new acceptance on the draining edge gives full throughput.
- Dependent back-to-back R-type with WB_LAT = 2: producer accepted at t; consumer stalls at t+1 and t+2 and is accepted at edge t+3.
- branch_flag is high in the cycle after the accepting edge, for exactly one cycle. It is unaffected by out_ready backpressure.
- Simultaneous flush and out_ready: flush wins, entry discarded.
- Reset mid-operation: all state clears immediately (asynchronous). The first acceptance is possible on the first edge after rst deasserts.

## Structure
- Shared package/define file holds:
  - opcode values (OP_SPECIAL, OP_SPECIAL2)
  - funct values (FUNCT_JR, FUNCT_JALR)
  - instruction segment positions
  - FSM state encodings RUN/DSLOT
  - ZERO_WORD and ZERO_REG_ADDR
- One sub-module, reg_scoreboard: counter array, load/decrement logic, two-port hazard lookup. Parameterised by REG_AW and WB_LAT.

## Test plan
- Reset: hold rst low with random inputs -> all outputs 0, in_ready 1 for a non-R inst. Release, then issue ADDU $3,$1,$2 with data 5/7 -> next cycle operand_1 = 5, operand_2 = 7, write_reg_addr = 3.
- RAW stall, WB_LAT = 2: ADDU $4 then SUBU $5,$4,$1 back-to-back -> in_ready low for 2 cycles, consumer issues on the 3rd cycle. An independent instruction in that slot issues with no stall.
- JALR $31,$8, pc = 0x100, $8 = 0x2000 -> branch_flag pulse with branch_addr 0x2000, operand_1 = 0x108, write $31; FSM in DSLOT until the next acceptance.
- Jump in delay slot: JR then JR -> second issues as NOP (write_reg_en 0, no pulse), dslot_err = 1.
- Backpressure: out_ready low for 5 cycles -> outputs stable, in_ready low. Raise out_ready together with a pending in_valid -> drain and load on the same edge.
- Flush: flush with out_valid = 1 and out_ready = 1 in the same cycle -> entry discarded, cnt[rd] = 0, so a dependent instruction is accepted the next cycle.
